// File: rtl/tlc_multi_ctrl.sv
// Multi-approach traffic-light controller: tick prescaler, demand latching, round-robin service
// with rest-in-green. Optional protected-left phase enabled by defining TLC_LEFT_PHASE_EN.
module tlc_multi_ctrl #(
    parameter int unsigned N_APP    = 2,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned TW       = 8,
    parameter int unsigned T_GREEN  = 8,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_LEFT   = 4,
    parameter int unsigned T_ALLRED = 1
) (
    input  logic             MCLK,
    input  logic             RESET,
    input  logic [N_APP-1:0] REQ,
    output logic [N_APP-1:0] GREEN,
    output logic [N_APP-1:0] LEFT,
    output logic [N_APP-1:0] YELLOW,
    output logic [N_APP-1:0] RED,
    output logic [1:0]       ACTIVE,
    output logic             TICK,
    output logic [TW-1:0]    TIMER
);

    localparam int unsigned     CW     = $clog2(TICK_DIV);
    localparam int unsigned     AIW    = $clog2(N_APP);
    localparam logic [CW-1:0]   CntMax = CW'(TICK_DIV - 1);
    localparam logic [N_APP-1:0] One   = {{(N_APP-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StAllRed, StLeft, StGreen, StYellow} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick_now;
    logic             tick_q;
    logic [1:0]       active_q, active_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [N_APP-1:0] pend_q, pend_d;
    logic [N_APP-1:0] green_q, green_d;
    logic [N_APP-1:0] left_q, left_d;
    logic [N_APP-1:0] yellow_q, yellow_d;
    logic [N_APP-1:0] red_q, red_d;

    logic [N_APP-1:0] act_mask;
    logic [N_APP-1:0] next_mask;
    logic             serving;
    logic             other_pend;
    logic             enter;
    logic [1:0]       rr_next;
    int               rr_idx;
    logic [TW-1:0]    load_len;

    assign tick_now = (cnt_q == CntMax);
    assign act_mask = One << active_q;

    // Search ACTIVE+N_APP down to ACTIVE+1 so the nearest pending approach wins last.
    always_comb begin
        rr_idx  = (int'(active_q) + 1) % int'(N_APP);
        rr_next = 2'(rr_idx);
        for (int k = int'(N_APP); k >= 1; k--) begin
            rr_idx = (int'(active_q) + k) % int'(N_APP);
            if (pend_q[rr_idx[AIW-1:0]]) begin
                rr_next = 2'(rr_idx);
            end
        end
    end

    always_comb begin
        cnt_d      = tick_now ? '0 : cnt_q + CW'(1);
        state_d    = state_q;
        active_d   = active_q;
        timer_d    = timer_q;
        enter      = 1'b0;
        serving    = (state_q == StGreen) || (state_q == StLeft);
        other_pend = |(pend_q & ~act_mask);
        pend_d     = pend_q | (REQ & ~(serving ? act_mask : '0));

        if (tick_now) begin
            if (timer_q > TW'(1)) begin
                timer_d = timer_q - TW'(1);
            end else begin
                unique case (state_q)
                    StAllRed: begin
                        active_d = rr_next;
                        enter    = 1'b1;
`ifdef TLC_LEFT_PHASE_EN
                        state_d  = StLeft;
`else
                        state_d  = StGreen;
`endif
                    end
                    StLeft: begin
                        state_d = StGreen;
                        enter   = 1'b1;
                    end
                    StGreen: begin
                        // Rest in green: timer stays at 1 until another approach is waiting.
                        if (other_pend) begin
                            state_d = StYellow;
                        end
                    end
                    StYellow: state_d = StAllRed;
                    default:  state_d = StAllRed;
                endcase
            end
        end

        unique case (state_d)
            StAllRed: load_len = TW'(T_ALLRED);
            StLeft:   load_len = TW'(T_LEFT);
            StGreen:  load_len = TW'(T_GREEN);
            StYellow: load_len = TW'(T_YELLOW);
            default:  load_len = TW'(T_ALLRED);
        endcase
        if (state_d != state_q) begin
            timer_d = load_len;
        end

        next_mask = One << active_d;
        // Clearing on entry takes priority over a same-cycle set.
        if (enter) begin
            pend_d = pend_d & ~next_mask;
        end

        green_d  = (state_d == StGreen) ? next_mask : '0;
        yellow_d = (state_d == StYellow) ? next_mask : '0;
`ifdef TLC_LEFT_PHASE_EN
        left_d   = (state_d == StLeft) ? next_mask : '0;
`else
        left_d   = '0;
`endif
        red_d    = ~(green_d | yellow_d | left_d);
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= StAllRed;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            active_q <= 2'(N_APP - 1);
            timer_q  <= TW'(T_ALLRED);
            pend_q   <= '0;
            green_q  <= '0;
            left_q   <= '0;
            yellow_q <= '0;
            red_q    <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_now;
            active_q <= active_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            green_q  <= green_d;
            left_q   <= left_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    assign GREEN  = green_q;
    assign LEFT   = left_q;
    assign YELLOW = yellow_q;
    assign RED    = red_q;
    assign ACTIVE = active_q;
    assign TICK   = tick_q;
    assign TIMER  = timer_q;

endmodule

// File: tb/tb_tlc_multi_ctrl.sv
// Randomised bench for tlc_multi_ctrl: a 2-approach and a 4-approach instance run side by side
// against a tick-level reference model of the light sequence.
module tb_tlc_multi_ctrl;

    localparam int Div = 4;
    localparam int Tg  = 3;
    localparam int Ty  = 2;
    localparam int Tl  = 2;
    localparam int Ta  = 1;
`ifdef TLC_LEFT_PHASE_EN
    localparam bit LeftEn = 1'b1;
`else
    localparam bit LeftEn = 1'b0;
`endif

    localparam int PhAllRed = 0;
    localparam int PhLeft   = 1;
    localparam int PhGreen  = 2;
    localparam int PhYellow = 3;

    logic       MCLK  = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] req2  = '0;
    logic [3:0] req4  = '0;

    logic [1:0] g2, l2, y2, r2, act2;
    logic       tick2;
    logic [7:0] tmr2;
    logic [3:0] g4, l4, y4, r4;
    logic [1:0] act4;
    logic       tick4;
    logic [7:0] tmr4;

    int checks = 0;
    int errors = 0;

    int       nap    [2] = '{2, 4};
    int       m_cnt  [2];
    int       m_ph   [2];
    int       m_rem  [2];
    int       m_act  [2];
    bit       m_tick [2];
    bit [3:0] m_pend [2];

    always #5 MCLK = ~MCLK;

    tlc_multi_ctrl #(
        .N_APP(2), .TICK_DIV(Div), .TW(8), .T_GREEN(Tg), .T_YELLOW(Ty), .T_LEFT(Tl), .T_ALLRED(Ta)
    ) u_dut2 (
        .MCLK(MCLK), .RESET(RESET), .REQ(req2), .GREEN(g2), .LEFT(l2), .YELLOW(y2), .RED(r2),
        .ACTIVE(act2), .TICK(tick2), .TIMER(tmr2)
    );

    tlc_multi_ctrl #(
        .N_APP(4), .TICK_DIV(Div), .TW(8), .T_GREEN(Tg), .T_YELLOW(Ty), .T_LEFT(Tl), .T_ALLRED(Ta)
    ) u_dut4 (
        .MCLK(MCLK), .RESET(RESET), .REQ(req4), .GREEN(g4), .LEFT(l4), .YELLOW(y4), .RED(r4),
        .ACTIVE(act4), .TICK(tick4), .TIMER(tmr4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        m_cnt[k]  = 0;
        m_ph[k]   = PhAllRed;
        m_rem[k]  = Ta;
        m_act[k]  = nap[k] - 1;
        m_tick[k] = 1'b0;
        m_pend[k] = '0;
    endtask

    // Advance model k by one clock given the request vector present before the edge.
    task automatic model_step(input int k, input bit [3:0] req);
        bit       tick;
        bit [3:0] np;
        bit [3:0] others;
        int       n;
        int       nxt;
        bit       found;
        n    = nap[k];
        tick = (m_cnt[k] == Div - 1);
        m_cnt[k]  = tick ? 0 : m_cnt[k] + 1;
        m_tick[k] = tick;
        np = m_pend[k];
        for (int i = 0; i < n; i++) begin
            if (req[i] && !((m_ph[k] == PhGreen || m_ph[k] == PhLeft) && m_act[k] == i)) np[i] = 1'b1;
        end
        if (tick) begin
            if (m_rem[k] > 1) begin
                m_rem[k]--;
            end else begin
                case (m_ph[k])
                    PhAllRed: begin
                        nxt   = (m_act[k] + 1) % n;
                        found = 1'b0;
                        for (int d = 1; d <= n; d++) begin
                            if (!found && m_pend[k][(m_act[k] + d) % n]) begin
                                nxt   = (m_act[k] + d) % n;
                                found = 1'b1;
                            end
                        end
                        m_act[k] = nxt;
                        m_ph[k]  = LeftEn ? PhLeft : PhGreen;
                        m_rem[k] = LeftEn ? Tl : Tg;
                        np[nxt]  = 1'b0;
                    end
                    PhLeft: begin
                        m_ph[k]  = PhGreen;
                        m_rem[k] = Tg;
                        np[m_act[k]] = 1'b0;
                    end
                    PhGreen: begin
                        others = m_pend[k];
                        others[m_act[k]] = 1'b0;
                        if (others != 0) begin
                            m_ph[k]  = PhYellow;
                            m_rem[k] = Ty;
                        end
                    end
                    default: begin
                        m_ph[k]  = PhAllRed;
                        m_rem[k] = Ta;
                    end
                endcase
            end
        end
        m_pend[k] = np;
    endtask

    task automatic compare(input int k);
        bit [3:0]   eg, el, ey, er, mask;
        logic [3:0] ag, al, ay, ar;
        logic [1:0] aa;
        logic       at;
        logic [7:0] atm;
        eg = '0; el = '0; ey = '0; er = '0; mask = '0;
        for (int i = 0; i < nap[k]; i++) begin
            mask[i] = 1'b1;
            if (m_act[k] == i) begin
                eg[i] = (m_ph[k] == PhGreen);
                el[i] = (m_ph[k] == PhLeft);
                ey[i] = (m_ph[k] == PhYellow);
            end
            er[i] = !(eg[i] || el[i] || ey[i]);
        end
        if (k == 0) begin
            ag = {2'b00, g2}; al = {2'b00, l2}; ay = {2'b00, y2}; ar = {2'b00, r2};
            aa = act2; at = tick2; atm = tmr2;
        end else begin
            ag = g4; al = l4; ay = y4; ar = r4; aa = act4; at = tick4; atm = tmr4;
        end
        check_eq($sformatf("n%0d_green", nap[k]), 32'(ag), 32'(eg));
        check_eq($sformatf("n%0d_left", nap[k]), 32'(al), 32'(el));
        check_eq($sformatf("n%0d_yellow", nap[k]), 32'(ay), 32'(ey));
        check_eq($sformatf("n%0d_red", nap[k]), 32'(ar), 32'(er));
        check_eq($sformatf("n%0d_active", nap[k]), 32'(aa), 32'(m_act[k]));
        check_eq($sformatf("n%0d_tick", nap[k]), 32'(at), 32'(m_tick[k]));
        check_eq($sformatf("n%0d_timer", nap[k]), 32'(atm), 32'(m_rem[k]));
        check_eq($sformatf("n%0d_one_nonred", nap[k]), 32'($countones(~ar & mask) <= 1), 32'(1));
    endtask

    // Called at a falling edge; returns at the next falling edge with both DUTs checked.
    task automatic cycle(input bit [1:0] r2v, input bit [3:0] r4v);
        req2 = r2v;
        req4 = r4v;
        model_step(0, {2'b00, r2v});
        model_step(1, r4v);
        @(posedge MCLK);
        @(negedge MCLK);
        compare(0);
        compare(1);
    endtask

    function automatic bit [3:0] rand_req(input int pct);
        bit [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 99) < pct);
        return r;
    endfunction

    task automatic release_and_check_first();
        RESET = 1'b1;
        repeat (4) cycle(2'b00, 4'h0);
        check_eq("first_serve_lamp", 32'(LeftEn ? l2 : g2), 32'(2'b01));
        check_eq("first_tick", 32'(tick2), 32'(1));
        check_eq("first_active", 32'(act2), 32'(0));
    endtask

    initial begin
        bit [3:0] ra, rb;
        int       pct;
        int       budget;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge MCLK);
        compare(0);
        compare(1);
        check_eq("reset_red", 32'(r2), 32'(2'b11));
        check_eq("reset_timer", 32'(tmr2), 32'(Ta));

        release_and_check_first();
        repeat (40) cycle(2'b00, 4'h0);
        check_eq("rest_in_green", 32'(LeftEn ? 2'b01 : g2), 32'(2'b01));

        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 4)
                0: pct = 3;
                1: pct = 12;
                2: pct = 50;
                default: pct = 0;
            endcase
            ra = rand_req(pct);
            rb = rand_req(pct);
            cycle(ra[1:0], rb);
        end

        budget = 0;
        while (m_ph[0] != PhYellow && budget < 200) begin
            cycle(2'b11, 4'hF);
            budget++;
        end
        check_eq("yellow_reached", 32'(m_ph[0] == PhYellow), 32'(1));

        #1 RESET = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare(0);
        compare(1);
        check_eq("async_rst_yellow", 32'(y2), 32'(0));
        repeat (2) @(negedge MCLK);
        release_and_check_first();

        for (int c = 0; c < 800; c++) begin
            ra = rand_req(10);
            rb = rand_req(10);
            cycle(ra[1:0], rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
